// File: rtl/ttt_turn_ctrl.sv
// ---------------------------------------------------------------------------
// ttt_turn_ctrl
// Turn controller for a two-player tic-tac-toe game. It detects rising edges
// on each player's go strobe, validates the requested square, keeps both
// boards, evaluates the eight winning lines after every accepted move and
// reports the result.
//
// Ports
//   clk           in   1  sole clock, rising edge
//   reset         in   1  synchronous, active-high reset
//   x_go / o_go   in   1  move request strobes (rising edge only counts)
//   x_move/o_move in   9  one-hot square, bit 8 = top-left, bit 0 = bottom-right
//   x_board       out  9  squares owned by X
//   o_board       out  9  squares owned by O
//   x_turn        out  1  1 = X to move, 0 = O to move
//   bad_move      out  1  last in-turn request rejected (sticky until valid move)
//   x_wins        out  1  X completed a line
//   o_wins        out  1  O completed a line
//   draw_game     out  1  board full without a line
//   playing_game  out  1  game in progress
//   move_count    out  4  accepted moves, 0..9
// ---------------------------------------------------------------------------
module ttt_turn_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       x_go,
  input  logic [8:0] x_move,
  input  logic       o_go,
  input  logic [8:0] o_move,
  output logic [8:0] x_board,
  output logic [8:0] o_board,
  output logic       x_turn,
  output logic       bad_move,
  output logic       x_wins,
  output logic       o_wins,
  output logic       draw_game,
  output logic       playing_game,
  output logic [3:0] move_count
);

  localparam logic [1:0] S_X_TURN = 2'd0;
  localparam logic [1:0] S_O_TURN = 2'd1;
  localparam logic [1:0] S_EVAL   = 2'd2;
  localparam logic [1:0] S_OVER   = 2'd3;

  logic [1:0] r_state;
  logic       r_x_go_q;
  logic       r_o_go_q;
  logic [8:0] r_x_board;
  logic [8:0] r_o_board;
  logic       r_x_turn;
  logic       r_bad_move;
  logic       r_x_wins;
  logic       r_o_wins;
  logic       r_draw;
  logic       r_playing;
  logic [3:0] r_move_count;
  logic       r_last_x;     // 1 = the move under evaluation was made by X

  logic       w_x_req;
  logic       w_o_req;
  logic [8:0] w_occupied;
  logic       w_x_valid;
  logic       w_o_valid;
  logic [8:0] w_eval_board;
  logic       w_line;
  logic       w_full;

  // True when exactly one bit of the square vector is set.
  function automatic logic f_one_hot(input logic [8:0] m);
    f_one_hot = (m != 9'd0) && ((m & (m - 9'd1)) == 9'd0);
  endfunction

  // True when the board contains any of the eight complete lines.
  function automatic logic f_has_line(input logic [8:0] b);
    f_has_line = (b[8] & b[7] & b[6]) | (b[5] & b[4] & b[3]) |
                 (b[2] & b[1] & b[0]) | (b[8] & b[5] & b[2]) |
                 (b[7] & b[4] & b[1]) | (b[6] & b[3] & b[0]) |
                 (b[8] & b[4] & b[0]) | (b[6] & b[4] & b[2]);
  endfunction

  // Request detection, move validation and line evaluation.
  always_comb begin
    w_x_req      = x_go & ~r_x_go_q;
    w_o_req      = o_go & ~r_o_go_q;
    w_occupied   = r_x_board | r_o_board;
    w_x_valid    = f_one_hot(x_move) && ((x_move & w_occupied) == 9'd0);
    w_o_valid    = f_one_hot(o_move) && ((o_move & w_occupied) == 9'd0);
    if (r_last_x) begin
      w_eval_board = r_x_board;
    end else begin
      w_eval_board = r_o_board;
    end
    w_line       = f_has_line(w_eval_board);
    w_full       = (w_occupied == 9'h1FF);
  end

  // Game state machine and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      // go_q is cleared rather than loaded, so a go held through reset
      // release is seen as a fresh request on the first cycle after it.
      r_state      <= S_X_TURN;
      r_x_go_q     <= 1'b0;
      r_o_go_q     <= 1'b0;
      r_x_board    <= 9'd0;
      r_o_board    <= 9'd0;
      r_x_turn     <= 1'b1;
      r_bad_move   <= 1'b0;
      r_x_wins     <= 1'b0;
      r_o_wins     <= 1'b0;
      r_draw       <= 1'b0;
      r_playing    <= 1'b1;
      r_move_count <= 4'd0;
      r_last_x     <= 1'b1;
    end else begin
      r_x_go_q <= x_go;
      r_o_go_q <= o_go;
      case (r_state)
        S_X_TURN: begin
          if (w_x_req) begin
            if (w_x_valid) begin
              r_x_board    <= r_x_board | x_move;
              r_bad_move   <= 1'b0;
              r_move_count <= r_move_count + 4'd1;
              r_last_x     <= 1'b1;
              r_state      <= S_EVAL;
            end else begin
              r_bad_move   <= 1'b1;
            end
          end
        end
        S_O_TURN: begin
          if (w_o_req) begin
            if (w_o_valid) begin
              r_o_board    <= r_o_board | o_move;
              r_bad_move   <= 1'b0;
              r_move_count <= r_move_count + 4'd1;
              r_last_x     <= 1'b0;
              r_state      <= S_EVAL;
            end else begin
              r_bad_move   <= 1'b1;
            end
          end
        end
        S_EVAL: begin
          // A win is checked before the full-board test so that a line
          // completed on the ninth move is reported as a win, not a draw.
          if (w_line) begin
            r_x_wins  <= r_last_x;
            r_o_wins  <= ~r_last_x;
            r_playing <= 1'b0;
            r_state   <= S_OVER;
          end else if (w_full) begin
            r_draw    <= 1'b1;
            r_playing <= 1'b0;
            r_state   <= S_OVER;
          end else begin
            r_x_turn  <= ~r_last_x;
            if (r_last_x) begin
              r_state <= S_O_TURN;
            end else begin
              r_state <= S_X_TURN;
            end
          end
        end
        S_OVER: begin
          r_state <= S_OVER;
        end
        default: begin
          r_state <= S_X_TURN;
        end
      endcase
    end
  end

  assign x_board      = r_x_board;
  assign o_board      = r_o_board;
  assign x_turn       = r_x_turn;
  assign bad_move     = r_bad_move;
  assign x_wins       = r_x_wins;
  assign o_wins       = r_o_wins;
  assign draw_game    = r_draw;
  assign playing_game = r_playing;
  assign move_count   = r_move_count;

endmodule

// File: doc/ttt_turn_ctrl.md
TTT_TURN_CTRL -- requirements
Module: ttt_turn_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset; all ports are listed below as name, direction, width, meaning.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 x_go  input  1  player X move request; only a rising edge counts.
REQ-005 x_move  input  9  player X square, one-hot; bit 8 = top-left, bit 0 = bottom-right, row-major.
REQ-006 o_go  input  1  player O move request; only a rising edge counts.
REQ-007 o_move  input  9  player O square, one-hot, same mapping as x_move.
REQ-008 x_board  output  9  registered squares owned by X.
REQ-009 o_board  output  9  registered squares owned by O.
REQ-010 x_turn  output  1  1 = X to move, 0 = O to move.
REQ-011 bad_move  output  1  last in-turn request rejected.
REQ-012 x_wins / o_wins / draw_game  output  1 each  terminal result flags.
REQ-013 playing_game  output  1  game in progress.
REQ-014 move_count  output  4  accepted moves, 0..9.

Function
REQ-015 SHALL register x_go/o_go into x_go_q/o_go_q every cycle; request = go & ~go_q.
REQ-016 SHALL implement states X_TURN, O_TURN, EVAL, OVER.
REQ-017 In X_TURN only X requests are considered; O requests are ignored with no flag change, and vice versa in O_TURN.
REQ-018 Simultaneous X and O requests: only the current player's request is processed.
REQ-019 An in-turn request is valid iff the move has exactly one bit set and (move & (x_board | o_board)) == 0.
REQ-020 Valid request: OR the move into that player's board, clear bad_move, increment move_count, record last_player, go to EVAL at the next edge; the board is visible 1 cycle after the request edge.
REQ-021 Invalid request (zero bits, multiple bits, or occupied square): set bad_move=1, boards unchanged, state unchanged.
REQ-022 bad_move SHALL hold its value until the next valid move or reset.
REQ-023 EVAL lasts exactly 1 cycle and checks last_player's board against the 8 lines {8,7,6} {5,4,3} {2,1,0} {8,5,2} {7,4,1} {6,3,0} {8,4,0} {6,4,2}.
REQ-024 EVAL, line complete: set x_wins or o_wins (per last_player), go to OVER.
REQ-025 EVAL, no line and (x_board | o_board) == 9'h1FF: set draw_game, go to OVER; a win on the 9th move takes priority over draw.
REQ-026 EVAL, otherwise: go to the other player's turn state; x_turn toggles.
REQ-027 Requests arriving in EVAL are ignored; go_q still updates, so a go held high is not re-detected.
REQ-028 OVER holds the boards, the result flag and move_count until reset; all requests are ignored.
REQ-029 playing_game = 1 in X_TURN, O_TURN and EVAL; 0 in OVER.
REQ-030 move_count SHALL never exceed 9 (guaranteed by REQ-025).

Reset
REQ-031 reset SHALL win over every other event, including reset mid-EVAL and reset in OVER.
REQ-032 Reset values: state=X_TURN, x_board=o_board=0, x_turn=1, bad_move=0, x_wins=o_wins=draw_game=0, playing_game=1, move_count=0, x_go_q=o_go_q=0.
REQ-033 A go held high through reset release SHALL count as a request in the first post-reset cycle.

Verification
REQ-034 After reset, X pulses 100_000_000 -> 1 cycle later x_board=100_000_000, then EVAL, then x_turn=0, move_count=1.
REQ-035 O plays 100_000_000 (occupied) -> bad_move=1, boards unchanged; O then plays 000_000_001 -> bad_move=0, o_board=000_000_001.
REQ-036 X moves 8,4,0 interleaved with O moves 7,5 -> x_wins=1, playing_game=0, move_count=5; further go pulses change nothing.
REQ-037 Full board with no line (X: 8,6,5,3,1; O: 7,4,2,0 -- all 8 lines checked unblocked for neither) -> draw_game=1 on the cycle after the 9th move's EVAL.
REQ-038 O pulses during X_TURN, both go high together, an X move of 000_000_011, and an X move of 0 -> O ignored; X processed; the two-bit and zero moves set bad_move=1.
REQ-039 Reset asserted during EVAL and again in OVER -> all outputs return to the REQ-032 values on the next edge.
